// File: rtl/mod_n_cascade_counter_pkg.sv
// Shared definitions for the cascaded modulo-N counter: direction encoding
// and digit-width derivation.
package mod_n_cascade_counter_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    function automatic int unsigned calc_dw(input int unsigned modulus);
        return $clog2(modulus);
    endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-MODULUS stage: loads, steps up/down with wrap, and flags when it
// sits at the terminal value for the current direction.
module mod_n_digit
    import mod_n_cascade_counter_pkg::*;
#(
    parameter int unsigned MODULUS = 10,
    localparam int unsigned DW = calc_dw(MODULUS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_in_i,
    input  logic          up_i,
    input  logic          load_i,
    input  logic [DW-1:0] load_val_i,
    output logic [DW-1:0] digit_o,
    output logic          is_terminal_o
);

    localparam int unsigned DW1 = DW + 1;
    localparam logic [DW-1:0] MAX_VAL = DW'(MODULUS - 1);
    localparam logic [DW-1:0] ONE     = DW'(1);
    // One extra bit so MODULUS itself is representable when it is a power of two
    localparam logic [DW:0]   MOD_VAL = DW1'(MODULUS);

    logic [DW-1:0] digit_q;
    logic [DW-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            if ({1'b0, load_val_i} >= MOD_VAL) begin
                digit_d = '0;
            end else begin
                digit_d = load_val_i;
            end
        end else if (step_in_i) begin
            if (up_i == DIR_UP) begin
                digit_d = (digit_q == MAX_VAL) ? '0 : digit_q + ONE;
            end else begin
                digit_d = (digit_q == '0) ? MAX_VAL : digit_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o       = digit_q;
    assign is_terminal_o = (up_i == DIR_UP) ? (digit_q == MAX_VAL) : (digit_q == '0);

endmodule

// File: rtl/mod_n_cascade_counter.sv
// Cascaded modulo-N counter: DIGITS chained mod_n_digit stages with
// combinational carry/borrow ripple, terminal-count and sticky overflow.
module mod_n_cascade_counter
    import mod_n_cascade_counter_pkg::*;
#(
    parameter int unsigned MODULUS = 10,
    parameter int unsigned DIGITS  = 4,
    localparam int unsigned DW = calc_dw(MODULUS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    input  logic                 clr_ovf,
    output logic [DIGITS*DW-1:0] count,
    output logic                 tc,
    output logic                 ovf
);

    // step_chain[k] is the step enable of digit k; step_chain[DIGITS] means
    // every digit is terminal, i.e. the next enabled step wraps the chain.
    logic [DIGITS:0]   step_chain;
    logic [DIGITS-1:0] is_term;
    logic              wrap;
    logic              ovf_q;
    logic              ovf_d;

    assign step_chain[0] = en;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        mod_n_digit #(
            .MODULUS (MODULUS)
        ) u_digit (
            .clk           (clk),
            .rst           (rst),
            .step_in_i     (step_chain[k]),
            .up_i          (up),
            .load_i        (load),
            .load_val_i    (load_val[k*DW +: DW]),
            .digit_o       (count[k*DW +: DW]),
            .is_terminal_o (is_term[k])
        );
        assign step_chain[k+1] = step_chain[k] & is_term[k];
    end

    assign tc = step_chain[DIGITS];

    // A load on the same edge takes priority over the step, so no wrap occurs
    assign wrap = tc & ~load;

    always_comb begin
        ovf_d = ovf_q;
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Self-checking bench: two counter configurations (mod 10 x 2, mod 3 x 3)
// compared each cycle against an integer-valued reference model.
module tb_mod_n_cascade_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic       clr_ovf;
    logic [7:0] load_val10;
    logic [5:0] load_val3;
    logic [7:0] count10;
    logic [5:0] count3;
    logic       tc10, tc3, ovf10, ovf3;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state: whole-chain value as a plain integer in 0..N-1
    int unsigned m10_v = 0, m3_v = 0;
    logic        m10_ovf = 1'b0, m3_ovf = 1'b0;

    always #5 clk = ~clk;

    mod_n_cascade_counter #(.MODULUS(10), .DIGITS(2)) dut10 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val10),
        .clr_ovf(clr_ovf), .count(count10), .tc(tc10), .ovf(ovf10)
    );

    mod_n_cascade_counter #(.MODULUS(3), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val3),
        .clr_ovf(clr_ovf), .count(count3), .tc(tc3), .ovf(ovf3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned pack_digits(input int unsigned v, input int unsigned m,
                                                input int unsigned dw, input int unsigned nd);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < nd; i++) begin
            r = r | ((v % m) << (i * dw));
            v = v / m;
        end
        return r;
    endfunction

    function automatic int unsigned load_value(input int unsigned bits, input int unsigned m,
                                               input int unsigned dw, input int unsigned nd);
        int unsigned val, w, f;
        val = 0;
        w   = 1;
        for (int unsigned i = 0; i < nd; i++) begin
            f = (bits >> (i * dw)) & ((1 << dw) - 1);
            if (f >= m) f = 0;
            val = val + f * w;
            w   = w * m;
        end
        return val;
    endfunction

    function automatic logic model_tc(input int unsigned v, input int unsigned n);
        return en && (up ? (v == n - 1) : (v == 0));
    endfunction

    task automatic model_edge(inout int unsigned v, inout logic o,
                              input int unsigned n, input int unsigned lv);
        logic wrap;
        wrap = 1'b0;
        if (!rst) begin
            v = 0;
            o = 1'b0;
        end else begin
            if (load) begin
                v = lv;
            end else if (en) begin
                if (up) begin
                    wrap = (v == n - 1);
                    v = (v + 1) % n;
                end else begin
                    wrap = (v == 0);
                    v = (v + n - 1) % n;
                end
            end
            if (wrap) o = 1'b1;
            else if (clr_ovf) o = 1'b0;
        end
    endtask

    // Inputs are already set by the caller; check tc, clock once, check state.
    task automatic cycle();
        int unsigned lv10, lv3;
        #1;
        check("tc10", 32'(tc10), 32'(model_tc(m10_v, 100)));
        check("tc3",  32'(tc3),  32'(model_tc(m3_v, 27)));
        lv10 = load_value(32'(load_val10), 10, 4, 2);
        lv3  = load_value(32'(load_val3), 3, 2, 3);
        @(posedge clk);
        model_edge(m10_v, m10_ovf, 100, lv10);
        model_edge(m3_v, m3_ovf, 27, lv3);
        #1;
        check("count10", 32'(count10), pack_digits(m10_v, 10, 4, 2));
        check("ovf10",   32'(ovf10),   32'(m10_ovf));
        check("count3",  32'(count3),  pack_digits(m3_v, 3, 2, 3));
        check("ovf3",    32'(ovf3),    32'(m3_ovf));
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; clr_ovf = 1'b0;
        load_val10 = '0; load_val3 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then up-count through the full range and wrap
        cycle();
        check("rst_count", 32'(count10), 32'h00);
        check("rst_ovf", 32'(ovf10), 32'h0);
        rst = 1'b1;
        repeat (99) cycle();
        check("up_at_99", 32'(count10), 32'h99);
        check("up_tc_99", 32'(tc10), 32'h1);
        cycle();
        check("up_wrap_cnt", 32'(count10), 32'h00);
        check("up_wrap_ovf", 32'(ovf10), 32'h1);

        // Down-count from reset
        rst = 1'b0; up = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        check("dn_tc_00", 32'(tc10), 32'h1);
        cycle();
        check("dn_wrap_cnt", 32'(count10), 32'h99);
        check("dn_wrap_ovf", 32'(ovf10), 32'h1);
        cycle();
        check("dn_98", 32'(count10), 32'h98);
        repeat (99) cycle();
        check("dn_wrap2_cnt", 32'(count10), 32'h99);
        check("dn_wrap2_ovf", 32'(ovf10), 32'h1);

        // Load beats enable; out-of-range field loads 0
        up = 1'b1; load = 1'b1; load_val10 = 8'h57;
        cycle();
        check("load_57", 32'(count10), 32'h57);
        load_val10 = 8'h3C;
        cycle();
        check("load_3C", 32'(count10), 32'h30);

        // Clear race: wrap and clr_ovf on the same edge keeps ovf set
        load = 1'b0; en = 1'b0; clr_ovf = 1'b1;
        cycle();
        check("clr_idle", 32'(ovf10), 32'h0);
        clr_ovf = 1'b0; load = 1'b1; load_val10 = 8'h99;
        cycle();
        load = 1'b0; en = 1'b1; clr_ovf = 1'b1;
        cycle();
        check("race_ovf", 32'(ovf10), 32'h1);
        check("race_cnt", 32'(count10), 32'h00);
        en = 1'b0;
        cycle();
        check("clr_after", 32'(ovf10), 32'h0);
        clr_ovf = 1'b0;

        // Reset mid-operation
        load = 1'b1; load_val10 = 8'h46;
        cycle();
        load = 1'b0; en = 1'b1; rst = 1'b0;
        cycle();
        check("mid_rst_cnt", 32'(count10), 32'h00);
        check("mid_rst_ovf", 32'(ovf10), 32'h0);
        rst = 1'b1;
        cycle();
        check("resume_01", 32'(count10), 32'h01);

        // Base-3 chain: 27 up steps return to 000
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int unsigned i = 1; i <= 27; i++) begin
            cycle();
            if (i == 5) check("b3_step5", 32'(count3), 32'b00_01_10);
        end
        check("b3_wrap_cnt", 32'(count3), 32'h0);
        check("b3_wrap_ovf", 32'(ovf3), 32'h1);

        // Randomized traffic, biased towards terminal values
        for (int unsigned i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 49) != 0);
            en      = ($urandom_range(0, 3) != 0);
            up      = 1'($urandom_range(0, 1));
            load    = ($urandom_range(0, 9) == 0);
            clr_ovf = ($urandom_range(0, 9) == 0);
            load_val10 = 8'($urandom);
            if ($urandom_range(0, 2) == 0) load_val10 = ($urandom_range(0, 1) != 0) ? 8'h99 : 8'h00;
            load_val3 = 6'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_n_cascade_counter.md
# mod_n_cascade_counter

Parametrised, cascaded modulo-N counter: DIGITS chained stages, each counting modulo MODULUS (decimal by default), with up/down direction, synchronous parallel load, count enable, terminal-count output and sticky overflow flag. It is the general counting primitive for timers, event tallies and display drivers. It replaces fixed single-digit mod-10 counters in new designs.

## Interface
- MODULUS, 10, per-digit modulus; legal range 2..65536.
- DIGITS, 4, number of cascaded stages; at least 1.
- DW (derived localparam), $clog2(MODULUS), bits per digit.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  DIGITS*DW  load value; digit k occupies bits [k*DW +: DW], digit 0 is least significant.
- clr_ovf  in  1  clears ovf.
- count  out  DIGITS*DW  current value, same packing as load_val.
- tc  out  1  terminal count: the next enabled step wraps the whole chain.
- ovf  out  1  sticky: chain has wrapped since the last clear or reset.

## Operation
- Priority per clock edge: rst low > load > en > hold.
- rst low: every digit goes to 0 and ovf goes to 0. load, en and clr_ovf are ignored that cycle.
- load: each digit takes its load_val field. A field >= MODULUS loads 0 for that digit only. load never sets or clears ovf, except through clr_ovf.
- en with up=1:
  - Digit 0 increments, wrapping MODULUS-1 -> 0.
  - Digit k>0 steps only when digits 0..k-1 all equal MODULUS-1.
- en with up=0:
  - Digit 0 decrements, wrapping 0 -> MODULUS-1.
  - Digit k>0 steps only when digits 0..k-1 all equal 0.
- Chain wrap, i.e. an enabled step with all digits at terminal value (MODULUS-1 up, 0 down):
  - all digits wrap together (up: all -> 0; down: all -> MODULUS-1);
  - ovf sets on that edge.
- en low: all digits and ovf hold (clr_ovf still acts).
- ovf update:
  - clr_ovf clears ovf on the next edge.
  - clr_ovf and a chain wrap on the same edge: set wins, ovf = 1.
- Direction changes take effect immediately; no pipeline to drain.
- count is a direct register output.

## Timing
- Reset values: count = 0, ovf = 0. tc after reset: en && !up.
- Latency: load, step and reset are all visible on count one cycle after the sampling edge.
- ovf is registered and asserts in the same cycle as the wrapped count value appears.
- tc is combinational from the registered digits, en and up:
  - tc = en && (all digits terminal for the current direction);
  - no registered delay.
- tc is not gated by load. A load in the same cycle suppresses the wrap and ovf, even though tc is high.
- Carry/borrow ripple is combinational across all DIGITS within one cycle. No multi-cycle carry.

## Structure
- Shared package holds the direction constants (DIR_UP = 1, DIR_DN = 0) and a function computing DW from MODULUS.
- One sub-module, mod_n_digit: a single stage with
  - inputs: step_in, up, load, load field;
  - outputs: its digit and an is_terminal flag.
- The top generates DIGITS instances of mod_n_digit and chains step_in(k) = en && AND(is_terminal of digits 0..k-1).
- ovf and tc logic live in the top.

## Test plan
- Reset and up-count (MODULUS=10, DIGITS=2): hold rst low, then release with en=1, up=1.
  - Required: count 00, 01, …, 09, 10; tc high only while count=99.
  - The edge after 99 gives 00 with ovf=1.
- Down-count from reset (MODULUS=10, DIGITS=2), en=1, up=0:
  - tc=1 at 00; next edge gives count=99, ovf=1;
  - then 98; a further wrap keeps ovf=1.
- Load: load=1 with load_val=0x57 and en=1 on the same edge -> count=57, no step. Then load_val digit0=0xC, digit1=3 -> count=30.
- Clear race: at count 99 with up=1, en=1, assert clr_ovf on the wrapping edge -> ovf stays 1. clr_ovf alone on the next edge -> ovf=0.
- Reset mid-operation: at count 46 with en=1, pull rst low for one edge -> count=00, ovf=0. Counting resumes 01 on the next edge.
- Non-decimal modulus (MODULUS=3, DIGITS=3): 27 enabled up steps -> returns to 000 with ovf=1. Digit patterns follow base 3 (e.g. step 5 -> 012).
